// File: rtl/digout_frame_tx_if.sv
// digout_frame_tx_if: payload handshake and serial-output bundle for
// digout_frame_tx.
//   mode        - 0 = internal counter payload, 1 = external payload
//   data_in     - NCH packed channel words, channel c at [c*DATA_W +: DATA_W]
//   data_valid  - external word available
//   data_ready  - transmitter can accept data_in this cycle
//   q           - registered serial output
//   busy        - group in progress
//   frame_done  - pulse on the last bit cycle of each frame
//   group_cnt   - payload of the next counter-mode group
interface digout_frame_tx_if #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned NCH    = 4
);
  logic                    mode;
  logic [NCH*DATA_W-1:0]   data_in;
  logic                    data_valid;
  logic                    data_ready;
  logic                    q;
  logic                    busy;
  logic                    frame_done;
  logic [DATA_W-1:0]       group_cnt;

  modport master (
    output mode, data_in, data_valid,
    input  data_ready, q, busy, frame_done, group_cnt
  );

  modport slave (
    input  mode, data_in, data_valid,
    output data_ready, q, busy, frame_done, group_cnt
  );
endinterface

// File: rtl/digout_frame_tx.sv
// digout_frame_tx: serial debug-frame transmitter, one bit per clk.
// Sends a group of NCH frames (sync ones, channel ID MSB first, payload,
// optional even parity, stop zero, zero gap). Payload is either a
// free-running group counter (mode=0) or an externally loaded
// multi-channel word (mode=1, valid/ready handshake).
//   clk  - clock, all logic on posedge
//   rst  - synchronous active-high reset
//   bus  - digout_frame_tx_if slave modport (handshake, payload, outputs)
module digout_frame_tx #(
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned NCH       = 4,
  parameter int unsigned SYNC_LEN  = 2,
  parameter int unsigned GAP_LEN   = 8,
  parameter int unsigned PARITY_EN = 1,
  parameter int unsigned MSB_FIRST = 0
) (
  input  logic             clk,
  input  logic             rst,
  digout_frame_tx_if.slave bus
);

  localparam int unsigned CH_W = (NCH <= 1) ? 1 : $clog2(NCH);

  typedef enum logic [2:0] {IDLE, SYNC, CHID, DATA, PAR, STOP, GAP} state_t;

  state_t                state_q, state_d;
  logic [7:0]            cnt_q, cnt_d;
  logic [CH_W-1:0]       ch_q, ch_d;
  logic [NCH*DATA_W-1:0] buf_q, buf_d;
  logic [DATA_W-1:0]     grp_q, grp_d;
  logic                  q_q, q_d;

  logic                  load;
  logic                  frame_end;
  logic [DATA_W-1:0]     word;
  logic [DATA_W-1:0]     word_sh;
  logic [CH_W-1:0]       ch_sh;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ch_d      = ch_q;
    buf_d     = buf_q;
    grp_d     = grp_q;
    load      = 1'b0;
    frame_end = 1'b0;

    case (state_q)
      IDLE: begin
        load = bus.mode ? bus.data_valid : 1'b1;
        if (load) begin
          state_d = SYNC;
          cnt_d   = '0;
          ch_d    = '0;
          if (bus.mode) begin
            buf_d = bus.data_in;
          end else begin
            buf_d = {NCH{grp_q}};
            grp_d = grp_q + DATA_W'(1);
          end
        end
      end
      SYNC: begin
        if (cnt_q == 8'(SYNC_LEN - 1)) begin
          state_d = CHID;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      CHID: begin
        if (cnt_q == 8'(CH_W - 1)) begin
          state_d = DATA;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      DATA: begin
        if (cnt_q == 8'(DATA_W - 1)) begin
          state_d = (PARITY_EN != 0) ? PAR : STOP;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      PAR: begin
        state_d = STOP;
        cnt_d   = '0;
      end
      STOP: begin
        if (GAP_LEN == 0) begin
          frame_end = 1'b1;
        end else begin
          state_d = GAP;
          cnt_d   = '0;
        end
      end
      GAP: begin
        if (cnt_q == 8'(GAP_LEN - 1)) begin
          frame_end = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (frame_end) begin
      cnt_d = '0;
      if (ch_q == CH_W'(NCH - 1)) begin
        state_d = IDLE;
      end else begin
        ch_d    = ch_q + CH_W'(1);
        state_d = SYNC;
      end
    end

    // q is registered, so the bit is chosen from the next state/position;
    // buf_d is used so a just-loaded word is already visible.
    word = '0;
    for (int unsigned c = 0; c < NCH; c++) begin
      if (ch_d == CH_W'(c)) word = buf_d[c*DATA_W +: DATA_W];
    end
    ch_sh   = ch_d << cnt_d;
    word_sh = (MSB_FIRST != 0) ? (word << cnt_d) : (word >> cnt_d);

    case (state_d)
      SYNC:    q_d = 1'b1;
      CHID:    q_d = ch_sh[CH_W-1];
      DATA:    q_d = (MSB_FIRST != 0) ? word_sh[DATA_W-1] : word_sh[0];
      PAR:     q_d = (^ch_d) ^ (^word);
      default: q_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ch_q    <= '0;
      buf_q   <= '0;
      grp_q   <= '0;
      q_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ch_q    <= ch_d;
      buf_q   <= buf_d;
      grp_q   <= grp_d;
      q_q     <= q_d;
    end
  end

  assign bus.q          = q_q;
  assign bus.busy       = (state_q != IDLE);
  assign bus.group_cnt  = grp_q;
  assign bus.data_ready = (state_q == IDLE) & bus.mode & ~rst;
  assign bus.frame_done = (GAP_LEN == 0) ? (state_q == STOP)
                                         : ((state_q == GAP) && (cnt_q == 8'(GAP_LEN - 1)));

endmodule

// File: tb/tb_digout_frame_tx.sv
module tb_digout_frame_tx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Three configurations: defaults, 4-bit wrap, and a variant
  // (MSB first, no parity, no gap, single channel).
  int unsigned cfg_dw[3]   = '{16, 4, 8};
  int unsigned cfg_nch[3]  = '{4, 2, 1};
  int unsigned cfg_sync[3] = '{2, 2, 3};
  int unsigned cfg_gap[3]  = '{8, 1, 0};
  int unsigned cfg_par[3]  = '{1, 1, 0};
  int unsigned cfg_msb[3]  = '{0, 0, 1};

  logic        rst_v[3];
  logic        mode_v[3];
  logic        valid_v[3];
  logic [63:0] din_v[3];

  logic        dq[3], dbusy[3], dfd[3], drdy[3];
  logic [31:0] dcnt[3];

  digout_frame_tx_if #(.DATA_W(16), .NCH(4)) if0 ();
  digout_frame_tx_if #(.DATA_W(4),  .NCH(2)) if1 ();
  digout_frame_tx_if #(.DATA_W(8),  .NCH(1)) if2 ();

  digout_frame_tx #(.DATA_W(16), .NCH(4), .SYNC_LEN(2), .GAP_LEN(8), .PARITY_EN(1), .MSB_FIRST(0))
    dut0 (.clk(clk), .rst(rst_v[0]), .bus(if0));
  digout_frame_tx #(.DATA_W(4), .NCH(2), .SYNC_LEN(2), .GAP_LEN(1), .PARITY_EN(1), .MSB_FIRST(0))
    dut1 (.clk(clk), .rst(rst_v[1]), .bus(if1));
  digout_frame_tx #(.DATA_W(8), .NCH(1), .SYNC_LEN(3), .GAP_LEN(0), .PARITY_EN(0), .MSB_FIRST(1))
    dut2 (.clk(clk), .rst(rst_v[2]), .bus(if2));

  assign if0.mode = mode_v[0];  assign if0.data_valid = valid_v[0];  assign if0.data_in = din_v[0];
  assign if1.mode = mode_v[1];  assign if1.data_valid = valid_v[1];  assign if1.data_in = din_v[1][7:0];
  assign if2.mode = mode_v[2];  assign if2.data_valid = valid_v[2];  assign if2.data_in = din_v[2][7:0];

  assign dq[0] = if0.q;  assign dbusy[0] = if0.busy;  assign dfd[0] = if0.frame_done;
  assign drdy[0] = if0.data_ready;  assign dcnt[0] = 32'(if0.group_cnt);
  assign dq[1] = if1.q;  assign dbusy[1] = if1.busy;  assign dfd[1] = if1.frame_done;
  assign drdy[1] = if1.data_ready;  assign dcnt[1] = 32'(if1.group_cnt);
  assign dq[2] = if2.q;  assign dbusy[2] = if2.busy;  assign dfd[2] = if2.frame_done;
  assign drdy[2] = if2.data_ready;  assign dcnt[2] = 32'(if2.group_cnt);

  int checks = 0;
  int failures = 0;
  logic started = 1'b0;

  task automatic chk(input string nm, input int id, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s dut%0d t=%0t got=%0h exp=%0h", nm, id, $time, got, exp);
    end
  endtask

  // Model: a group is expanded into a queue of {frame_done, q} entries,
  // one per bit cycle, straight from the frame layout rules.
  logic [1:0]  mq[3][$];
  logic        cur_q[3], cur_fd[3], cur_busy[3];
  int unsigned mcnt[3];

  task automatic push(input int id, input int unsigned b, input bit fd);
    logic [1:0] e;
    e = {fd, b[0]};
    mq[id].push_back(e);
  endtask

  task automatic model_step(input int id);
    int unsigned dw, nch, chw, mask, w, ones, bv, pos;
    logic [1:0] e;
    dw   = cfg_dw[id];
    nch  = cfg_nch[id];
    chw  = (nch <= 1) ? 1 : $clog2(nch);
    mask = (32'd1 << dw) - 1;
    if (rst_v[id]) begin
      mq[id].delete();
      cur_q[id] = 1'b0; cur_fd[id] = 1'b0; cur_busy[id] = 1'b0;
      mcnt[id] = 0;
    end else if (!cur_busy[id]) begin
      if (!mode_v[id] || valid_v[id]) begin
        for (int unsigned c = 0; c < nch; c++) begin
          w = mode_v[id] ? (32'(din_v[id] >> (c * dw)) & mask) : mcnt[id];
          ones = 0;
          for (int unsigned s = 0; s < cfg_sync[id]; s++) push(id, 1, 1'b0);
          for (int b = int'(chw) - 1; b >= 0; b--) begin
            bv = (c >> b) & 1;
            ones += bv;
            push(id, bv, 1'b0);
          end
          for (int unsigned i = 0; i < dw; i++) begin
            pos = (cfg_msb[id] != 0) ? (dw - 1 - i) : i;
            bv = (w >> pos) & 1;
            ones += bv;
            push(id, bv, 1'b0);
          end
          if (cfg_par[id] != 0) push(id, ones % 2, 1'b0);
          push(id, 0, cfg_gap[id] == 0);
          for (int unsigned g = 0; g < cfg_gap[id]; g++) push(id, 0, g == cfg_gap[id] - 1);
        end
        if (!mode_v[id]) mcnt[id] = (mcnt[id] + 1) & mask;
        e = mq[id].pop_front();
        cur_q[id] = e[0]; cur_fd[id] = e[1]; cur_busy[id] = 1'b1;
      end
    end else if (mq[id].size() > 0) begin
      e = mq[id].pop_front();
      cur_q[id] = e[0]; cur_fd[id] = e[1]; cur_busy[id] = 1'b1;
    end else begin
      cur_q[id] = 1'b0; cur_fd[id] = 1'b0; cur_busy[id] = 1'b0;
    end
  endtask

  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) model_step(i);
  end

  always @(negedge clk) begin
    if (started) begin
      for (int i = 0; i < 3; i++) begin
        chk("q", i, 32'(dq[i]), 32'(cur_q[i]));
        chk("busy", i, 32'(dbusy[i]), 32'(cur_busy[i]));
        chk("frame_done", i, 32'(dfd[i]), 32'(cur_fd[i]));
        chk("group_cnt", i, dcnt[i], mcnt[i]);
        chk("data_ready", i, 32'(drdy[i]), 32'(!cur_busy[i] && mode_v[i] && !rst_v[i]));
      end
    end
  end

  // Capture buffers for literal expectations.
  logic        capq[0:199], capfd[0:199], capbusy[0:199], caprdy[0:199];
  logic [31:0] capcnt[0:199];

  task automatic sample(input int id, input int k);
    capq[k] = dq[id]; capfd[k] = dfd[id]; capbusy[k] = dbusy[id];
    caprdy[k] = drdy[id]; capcnt[k] = dcnt[id];
  endtask

  // Index 0 is the current negedge; each further index is one cycle later.
  task automatic cap(input int id, input int from, input int to);
    for (int k = from; k <= to; k++) begin
      if (k > 0) @(negedge clk);
      sample(id, k);
    end
  endtask

  task automatic sync_idle(input int id);
    int n;
    n = 0;
    @(negedge clk);
    while (dbusy[id] !== 1'b0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("idle_wait", id, 32'(dbusy[id]), 32'd0);
  endtask

  function automatic logic [31:0] val(input int from, input int n, input bit msb);
    logic [31:0] v;
    v = '0;
    for (int i = 0; i < n; i++) begin
      if (msb) v[n-1-i] = capq[from+i];
      else     v[i]     = capq[from+i];
    end
    return v;
  endfunction

  function automatic int count_fd(input int from, input int to);
    int s;
    s = 0;
    for (int i = from; i <= to; i++) s += int'(capfd[i]);
    return s;
  endfunction

  function automatic int count_rdy(input int from, input int to);
    int s;
    s = 0;
    for (int i = from; i <= to; i++) s += int'(caprdy[i]);
    return s;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog t=%0t got=running exp=finished", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 3; i++) begin
      rst_v[i] = 1'b1; mode_v[i] = 1'b0; valid_v[i] = 1'b0; din_v[i] = '0;
    end
    @(posedge clk); #2 started = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    for (int i = 0; i < 3; i++) rst_v[i] = 1'b0;

    // Counter mode, first two groups.
    sync_idle(0);
    cap(0, 0, 142);
    chk("t1_reset_q", 0, 32'(capq[0]), 32'd0);
    chk("t1_reset_cnt", 0, capcnt[0], 32'd0);
    chk("t1_cnt_after_load", 0, capcnt[1], 32'd1);
    chk("t1_hdr_ch0", 0, {28'd0, capq[1], capq[2], capq[3], capq[4]}, 32'hC);
    chk("t1_hdr_ch1", 0, {28'd0, capq[31], capq[32], capq[33], capq[34]}, 32'hD);
    chk("t1_hdr_ch2", 0, {28'd0, capq[61], capq[62], capq[63], capq[64]}, 32'hE);
    chk("t1_hdr_ch3", 0, {28'd0, capq[91], capq[92], capq[93], capq[94]}, 32'hF);
    chk("t1_par", 0, {28'd0, capq[21], capq[51], capq[81], capq[111]}, 32'h6);
    chk("t1_fd_pos", 0, {28'd0, capfd[30], capfd[60], capfd[90], capfd[120]}, 32'hF);
    chk("t1_fd_count", 0, 32'(count_fd(1, 121)), 32'd4);
    chk("t1_idle", 0, {30'd0, capbusy[121], capq[121]}, 32'd0);
    chk("t1_g2_payload", 0, val(126, 16, 1'b0), 32'h0001);
    chk("t1_g2_par", 0, 32'(capq[142]), 32'd1);
    chk("t1_g2_cnt", 0, capcnt[122], 32'd2);

    // External mode; data_in changes mid-group must not reach the line.
    @(posedge clk); #2;
    mode_v[0] = 1'b1; valid_v[0] = 1'b1; din_v[0] = 64'h0000_FFFF_8001_A5A5;
    sync_idle(0);
    cap(0, 0, 59);
    din_v[0] = 64'h0001_0F0F_1234_5678;
    cap(0, 60, 121);
    chk("t2_ready_idle", 0, 32'(caprdy[0]), 32'd1);
    chk("t2_ready_busy", 0, 32'(count_rdy(1, 120)), 32'd0);
    chk("t2_ch0_data", 0, val(5, 16, 1'b0), 32'hA5A5);
    chk("t2_ch0_par", 0, 32'(capq[21]), 32'd0);
    chk("t2_ch1_data", 0, val(35, 16, 1'b0), 32'h8001);
    chk("t2_ch1_par", 0, 32'(capq[51]), 32'd1);
    chk("t3_ch2_old_data", 0, val(65, 16, 1'b0), 32'hFFFF);
    chk("t2_ch2_par", 0, 32'(capq[81]), 32'd1);
    chk("t2_ch3_data", 0, val(95, 16, 1'b0), 32'h0000);
    chk("t2_ch3_par", 0, 32'(capq[111]), 32'd0);
    chk("t3_ready_next_idle", 0, 32'(caprdy[121]), 32'd1);
    @(posedge clk); #2;
    mode_v[0] = 1'b0; valid_v[0] = 1'b0;

    // Variant: MSB first, no parity, no gap, single channel.
    mode_v[2] = 1'b1; valid_v[2] = 1'b1; din_v[2] = 64'hA3;
    sync_idle(2);
    cap(2, 0, 13);
    chk("t6_ready", 2, 32'(caprdy[0]), 32'd1);
    chk("t6_hdr", 2, {28'd0, capq[1], capq[2], capq[3], capq[4]}, 32'hE);
    chk("t6_data_msb", 2, val(5, 8, 1'b1), 32'hA3);
    chk("t6_stop_fd", 2, {30'd0, capq[13], capfd[13]}, 32'h1);
    chk("t6_fd_early", 2, 32'(count_fd(1, 12)), 32'd0);
    @(posedge clk); #2;
    mode_v[2] = 1'b0; valid_v[2] = 1'b0;

    // Reset during ch2 DATA bit 5, then clean restart in counter mode.
    sync_idle(0);
    repeat (70) @(posedge clk);
    #2 rst_v[0] = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("t4_rst_q", 0, 32'(dq[0]), 32'd0);
    chk("t4_rst_busy", 0, 32'(dbusy[0]), 32'd0);
    chk("t4_rst_cnt", 0, dcnt[0], 32'd0);
    @(posedge clk); #2 rst_v[0] = 1'b0;
    sync_idle(0);
    cap(0, 0, 21);
    chk("t4_restart_cnt", 0, capcnt[1], 32'd1);
    chk("t4_restart_hdr", 0, {28'd0, capq[1], capq[2], capq[3], capq[4]}, 32'hC);
    chk("t4_restart_data", 0, val(5, 16, 1'b0), 32'h0000);
    chk("t4_restart_par", 0, 32'(capq[21]), 32'd0);

    // Let the 4-bit counter configuration run well past its wrap.
    repeat (200) @(posedge clk);
    chk("t5_wrap_model_ran", 1, 32'(dcnt[1] < 32'd16), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
